stopwatch_ctrl: RTL and testbench

Mode controller that sequences the two `time_counter` instances (seconds and minutes) of the stopwatch.
- Generates the one-cycle count enables and the direction for both counters.
- Chains the seconds overflow into the minutes enable.
- Implements the run, pause, clear and adjust modes, including adjust-rate stepping and field blinking.
- Sits between the clock-divider ticks and debounced buttons on one side and the counters and display mux on the other.

---
 rtl/stopwatch_ctrl.sv | 172 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Mode controller for the stopwatch: sequences run/pause/clear/adjust and
// drives count enables, direction, counter reset and blink blanking.
module stopwatch_ctrl #(
   parameter int ADJ_DIV   = 2,
   parameter int BLINK_DIV = 4,
   parameter int DIV_W     = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_1hz,
   input  logic tick_fast,
   input  logic pause_p,
   input  logic clear_p,
   input  logic adj,
   input  logic sel,
   input  logic back,
   input  logic sec_ovf,
   input  logic min_ovf,
   output logic sec_en,
   output logic min_en,
   output logic dir,
   output logic cnt_rst,
   output logic blank_sec,
   output logic blank_min,
   output logic wrap,
   output logic running
);

   typedef enum logic [1:0] {
      ST_PAUSED = 2'b00,
      ST_RUN    = 2'b01,
      ST_ADJUST = 2'b10
   } state_t;

   localparam logic [DIV_W-1:0] ADJ_LAST   = DIV_W'(ADJ_DIV - 1);
   localparam logic [DIV_W-1:0] BLINK_LAST = DIV_W'(BLINK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ZERO   = DIV_W'(0);
   localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] adj_div_q, adj_div_d;
   logic [DIV_W-1:0] blink_div_q, blink_div_d;
   logic             blink_phase_q, blink_phase_d;
   logic             sec_en_q, sec_en_d;
   logic             min_en_q, min_en_d;
   logic             dir_q, dir_d;
   logic             cnt_rst_q, cnt_rst_d;
   logic             blank_sec_q, blank_sec_d;
   logic             blank_min_q, blank_min_d;
   logic             wrap_q, wrap_d;
   logic             running_q, running_d;

   // Next-state, divider and output computation; priority clear_p > adj > pause_p.
   always_comb begin
      state_d       = state_q;
      adj_div_d     = adj_div_q;
      blink_div_d   = blink_div_q;
      blink_phase_d = blink_phase_q;
      sec_en_d      = 1'b0;
      min_en_d      = 1'b0;
      wrap_d        = 1'b0;
      cnt_rst_d     = 1'b0;
      dir_d         = back;

      if (clear_p) begin
         cnt_rst_d     = 1'b1;
         state_d       = adj ? ST_ADJUST : ST_PAUSED;
         adj_div_d     = DIV_ZERO;
         blink_div_d   = DIV_ZERO;
         blink_phase_d = 1'b0;
      end else if (adj) begin
         if (state_q != ST_ADJUST) begin
            // Entering adjust restarts stepping and blinking from a clean phase.
            state_d       = ST_ADJUST;
            adj_div_d     = DIV_ZERO;
            blink_div_d   = DIV_ZERO;
            blink_phase_d = 1'b0;
         end else if (tick_fast) begin
            if (adj_div_q == ADJ_LAST) begin
               adj_div_d = DIV_ZERO;
               if (sel) begin
                  sec_en_d = 1'b1;
               end else begin
                  min_en_d = 1'b1;
               end
            end else begin
               adj_div_d = adj_div_q + DIV_ONE;
            end
            if (blink_div_q == BLINK_LAST) begin
               blink_div_d   = DIV_ZERO;
               blink_phase_d = ~blink_phase_q;
            end else begin
               blink_div_d = blink_div_q + DIV_ONE;
            end
         end else begin
            state_d = ST_ADJUST;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               // Enables follow the current state, so a tick alongside pause_p still counts.
               sec_en_d = tick_1hz;
               min_en_d = sec_ovf;
               wrap_d   = min_ovf;
               if (pause_p) begin
                  state_d = ST_PAUSED;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_PAUSED: begin
               if (pause_p) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_PAUSED;
               end
            end
            ST_ADJUST: begin
               state_d = ST_PAUSED;
            end
            default: begin
               state_d = ST_PAUSED;
            end
         endcase
      end

      blank_sec_d = (state_d == ST_ADJUST) &  sel & blink_phase_d;
      blank_min_d = (state_d == ST_ADJUST) & ~sel & blink_phase_d;
      running_d   = (state_d == ST_RUN);
   end

   // State, divider and registered-output flops with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_PAUSED;
         adj_div_q     <= DIV_ZERO;
         blink_div_q   <= DIV_ZERO;
         blink_phase_q <= 1'b0;
         sec_en_q      <= 1'b0;
         min_en_q      <= 1'b0;
         dir_q         <= 1'b0;
         cnt_rst_q     <= 1'b0;
         blank_sec_q   <= 1'b0;
         blank_min_q   <= 1'b0;
         wrap_q        <= 1'b0;
         running_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         adj_div_q     <= adj_div_d;
         blink_div_q   <= blink_div_d;
         blink_phase_q <= blink_phase_d;
         sec_en_q      <= sec_en_d;
         min_en_q      <= min_en_d;
         dir_q         <= dir_d;
         cnt_rst_q     <= cnt_rst_d;
         blank_sec_q   <= blank_sec_d;
         blank_min_q   <= blank_min_d;
         wrap_q        <= wrap_d;
         running_q     <= running_d;
      end
   end

   assign sec_en    = sec_en_q;
   assign min_en    = min_en_q;
   assign dir       = dir_q;
   assign cnt_rst   = cnt_rst_q;
   assign blank_sec = blank_sec_q;
   assign blank_min = blank_min_q;
   assign wrap      = wrap_q;
   assign running   = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus a random soak, checked
// cycle by cycle against a mode/tick-count reference model.
module tb_stopwatch_ctrl;

   localparam int ADJ_DIV   = 2;
   localparam int BLINK_DIV = 4;
   localparam int M_PAUSED  = 0;
   localparam int M_RUN     = 1;
   localparam int M_ADJUST  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick_1hz = 1'b0, tick_fast = 1'b0, pause_p = 1'b0, clear_p = 1'b0;
   logic adj = 1'b0, sel = 1'b0, back = 1'b0, sec_ovf = 1'b0, min_ovf = 1'b0;
   logic sec_en, min_en, dir, cnt_rst, blank_sec, blank_min, wrap, running;

   int checks = 0;
   int errors = 0;

   // Reference model: mode plus number of tick_fast pulses seen since entering adjust.
   int   m_mode  = M_PAUSED;
   int   m_ticks = 0;
   logic e_se, e_me, e_dir, e_cr, e_bs, e_bm, e_wr, e_run;

   stopwatch_ctrl #(.ADJ_DIV(ADJ_DIV), .BLINK_DIV(BLINK_DIV), .DIV_W(4)) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_fast(tick_fast),
      .pause_p(pause_p), .clear_p(clear_p), .adj(adj), .sel(sel), .back(back),
      .sec_ovf(sec_ovf), .min_ovf(min_ovf), .sec_en(sec_en), .min_en(min_en),
      .dir(dir), .cnt_rst(cnt_rst), .blank_sec(blank_sec), .blank_min(blank_min),
      .wrap(wrap), .running(running)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model();
      bit phase;
      e_se = 1'b0; e_me = 1'b0; e_wr = 1'b0; e_cr = 1'b0; e_dir = back;
      if (rst) begin
         m_mode = M_PAUSED; m_ticks = 0; e_dir = 1'b0;
      end else if (clear_p) begin
         e_cr = 1'b1; m_ticks = 0;
         m_mode = adj ? M_ADJUST : M_PAUSED;
      end else if (adj) begin
         if (m_mode != M_ADJUST) begin
            m_mode = M_ADJUST; m_ticks = 0;
         end else if (tick_fast) begin
            m_ticks++;
            if (m_ticks % ADJ_DIV == 0) begin
               if (sel) e_se = 1'b1;
               else     e_me = 1'b1;
            end
         end
      end else if (m_mode == M_ADJUST) begin
         m_mode = M_PAUSED;
      end else if (m_mode == M_RUN) begin
         e_se = tick_1hz; e_me = sec_ovf; e_wr = min_ovf;
         if (pause_p) m_mode = M_PAUSED;
      end else if (pause_p) begin
         m_mode = M_RUN;
      end
      phase = ((m_ticks / BLINK_DIV) % 2) == 1;
      e_bs  = (m_mode == M_ADJUST) &&  sel && phase;
      e_bm  = (m_mode == M_ADJUST) && !sel && phase;
      e_run = (m_mode == M_RUN);
   endtask

   // One clock: update model from current inputs, clock, compare, drop pulses.
   task automatic step();
      model();
      @(posedge clk);
      #1;
      chk("sec_en", sec_en, e_se);
      chk("min_en", min_en, e_me);
      chk("dir", dir, e_dir);
      chk("cnt_rst", cnt_rst, e_cr);
      chk("blank_sec", blank_sec, e_bs);
      chk("blank_min", blank_min, e_bm);
      chk("wrap", wrap, e_wr);
      chk("running", running, e_run);
      tick_1hz = 1'b0; tick_fast = 1'b0; pause_p = 1'b0; clear_p = 1'b0;
      sec_ovf = 1'b0; min_ovf = 1'b0;
   endtask

   initial begin
      // Reset
      rst = 1'b1; step(); step(); rst = 1'b0;
      step();

      // Run: 60 ticks, seconds overflow after the last one
      pause_p = 1'b1; step();
      for (int i = 0; i < 60; i++) begin
         back = 1'($urandom_range(0, 1));
         tick_1hz = 1'b1; step();
         if (i == 59) sec_ovf = 1'b1;
         step();
         repeat (8) step();
      end

      // Pause coincident with a tick, trailing overflows ignored
      tick_1hz = 1'b1; pause_p = 1'b1; step();
      for (int i = 0; i < 3; i++) begin
         tick_1hz = 1'b1; sec_ovf = 1'b1; step();
         repeat (3) step();
      end

      // Adjust seconds then minutes
      adj = 1'b1; sel = 1'b1; step();
      repeat (20) begin tick_fast = 1'b1; step(); end
      sel = 1'b0;
      repeat (20) begin tick_fast = 1'b1; step(); end

      // Clear while adjusting, then leave adjust
      clear_p = 1'b1; tick_fast = 1'b1; step();
      repeat (6) begin tick_fast = 1'b1; step(); end
      adj = 1'b0; step(); step();

      // Wrap only while running
      pause_p = 1'b1; step();
      min_ovf = 1'b1; step(); step();
      pause_p = 1'b1; step();
      min_ovf = 1'b1; step(); step();

      // Reset mid-adjust with blink phase high and divider mid-count
      adj = 1'b1; sel = 1'b1; step();
      repeat (5) begin tick_fast = 1'b1; step(); end
      rst = 1'b1; tick_fast = 1'b1; step(); rst = 1'b0;
      step();
      repeat (6) begin tick_fast = 1'b1; step(); end
      adj = 1'b0; step();

      // Random soak
      for (int i = 0; i < 4000; i++) begin
         rst       = ($urandom_range(0, 299) == 0);
         clear_p   = ($urandom_range(0, 59) == 0);
         pause_p   = ($urandom_range(0, 14) == 0);
         if ($urandom_range(0, 49) == 0) adj = ~adj;
         if ($urandom_range(0, 11) == 0) sel = ~sel;
         back      = 1'($urandom_range(0, 1));
         tick_1hz  = ($urandom_range(0, 3) == 0);
         tick_fast = ($urandom_range(0, 2) != 0);
         sec_ovf   = ($urandom_range(0, 4) == 0);
         min_ovf   = ($urandom_range(0, 4) == 0);
         step();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
